// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_pkg
//  Brief    : Shared types for the 5-stage pipeline (fetch FSM, IF/ID record).
//  Revision : 1.0
// ============================================================================
package pipeline_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_e;

    // sll $0,$0,0 -- architectural nop used for every bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc1;
        logic        valid;
    } ifid_t;

endpackage
`default_nettype wire

// File: rtl/ifid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : ifid_reg
//  Brief    : IF/ID pipeline register with load / bubble / hold controls.
//  Revision : 1.0
// ============================================================================
module ifid_reg
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] ins_i,
    input  logic [31:0] pc1_i,
    output ifid_t       entry_o
);

    ifid_t entry_q;

    // Bubble keeps pc1 so downstream sees a stable value; neither control holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else if (load_i) begin
            entry_q.ins   <= ins_i;
            entry_q.pc1   <= pc1_i;
            entry_q.valid <= 1'b1;
        end else if (bubble_i) begin
            entry_q.ins   <= NOP_INSTR;
            entry_q.valid <= 1'b0;
        end
    end

    assign entry_o = entry_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_stage
//  Brief    : IF stage: owns the word-indexed PC, fills IF/ID, halts out of range.
//             Optional FETCH_STATS_EN adds saturating fetch/stall counters.
//  Revision : 1.0
// ============================================================================
module instr_fetch_stage
    import pipeline_pkg::*;
#(
    parameter int          IMEM_DEPTH = 100,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_out,
    input  logic [31:0] ins_in,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] ifid_ins_o,
    output logic [31:0] ifid_pc1_o,
    output logic        ifid_valid_o,
    output logic        halted_o
`ifdef FETCH_STATS_EN
   ,output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_inc;
    logic         ifid_load, ifid_bubble;
    ifid_t        ifid_entry;

    assign pc_inc = pc_q + 32'd1;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: state_d = (pc_q >= DEPTH_W) ? S_HALT : S_RUN;
            S_RUN: begin
                if (redirect_i)
                    state_d = (redirect_pc_i >= DEPTH_W) ? S_HALT : S_RUN;
                else if (!stall_i && (pc_inc >= DEPTH_W))
                    state_d = S_HALT;
            end
            S_HALT: begin
                if (redirect_i)
                    state_d = (redirect_pc_i >= DEPTH_W) ? S_HALT : S_RUN;
            end
            default: state_d = S_BOOT;
        endcase
    end

    // ---------------- output / datapath control ----------------
    // Redirect wins over stall so a resolved branch is never lost behind a hazard.
    always_comb begin
        pc_d        = pc_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        case (state_q)
            S_BOOT: ifid_bubble = 1'b1;
            S_RUN, S_HALT: begin
                if (redirect_i) begin
                    pc_d        = redirect_pc_i;
                    ifid_bubble = 1'b1;
                end else if (stall_i) begin
                    ifid_bubble = 1'b0;
                end else if (state_q == S_HALT) begin
                    ifid_bubble = 1'b1;
                end else begin
                    pc_d = pc_inc;
                    if (flush_i) ifid_bubble = 1'b1;
                    else         ifid_load   = 1'b1;
                end
            end
            default: ifid_bubble = 1'b1;
        endcase
    end

    ifid_reg u_ifid_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .ins_i    (ins_in),
        .pc1_i    (pc_inc),
        .entry_o  (ifid_entry)
    );

    assign pc_out       = pc_q;
    assign ifid_ins_o   = ifid_entry.ins;
    assign ifid_pc1_o   = ifid_entry.pc1;
    assign ifid_valid_o = ifid_entry.valid;
    assign halted_o     = (state_q == S_HALT);

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (ifid_load && (fetch_cnt_q != 32'hFFFF_FFFF))
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_i && !redirect_i && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_stage
//  Brief    : Self-checking bench for instr_fetch_stage against a rule-level model.
//  Revision : 1.0
// ============================================================================
module tb_instr_fetch_stage;

    localparam int          DEPTH = 100;
    localparam logic [31:0] RPC   = 32'd0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_out;
    logic [31:0] ins_in;
    logic        stall_i, flush_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] ifid_ins_o, ifid_pc1_o;
    logic        ifid_valid_o, halted_o;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_o, stall_cnt_o;
`endif

    logic [31:0] mem [0:127];

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [31:0] m_pc, m_ins, m_pc1;
    logic        m_valid, m_halt, m_boot;
    longint      m_fetch, m_stall;

    always #5 clk = ~clk;

    assign ins_in = (pc_out < 32'd128) ? mem[pc_out[6:0]] : 32'hDEAD_BEEF;

    instr_fetch_stage #(.IMEM_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_out        (pc_out),
        .ins_in        (ins_in),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .ifid_ins_o    (ifid_ins_o),
        .ifid_pc1_o    (ifid_pc1_o),
        .ifid_valid_o  (ifid_valid_o),
        .halted_o      (halted_o)
`ifdef FETCH_STATS_EN
       ,.fetch_cnt_o   (fetch_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RPC; m_ins = 0; m_pc1 = 0; m_valid = 0; m_halt = 0; m_boot = 1;
        m_fetch = 0; m_stall = 0;
    endtask

    // One clock edge of the fetch stage described by its rules.
    task automatic model_step(input logic r, input logic [31:0] rpc, input logic s, input logic f);
        if (s && !r) m_stall++;
        if (m_boot) begin
            m_boot = 0;
            m_halt = (m_pc >= DEPTH);
        end else if (r) begin
            m_pc = rpc; m_ins = 0; m_valid = 0;
            m_halt = (rpc >= DEPTH);
        end else if (s) begin
            // everything holds
        end else if (m_halt) begin
            m_ins = 0; m_valid = 0;
        end else begin
            if (f) begin
                m_ins = 0; m_valid = 0;
            end else begin
                m_ins = mem[m_pc[6:0]]; m_pc1 = m_pc + 1; m_valid = 1; m_fetch++;
            end
            m_pc   = m_pc + 1;
            m_halt = (m_pc >= DEPTH);
        end
    endtask

    task automatic compare_all();
        check("pc_out", pc_out, m_pc);
        check("ifid_ins", ifid_ins_o, m_ins);
        check("ifid_pc1", ifid_pc1_o, m_pc1);
        check("ifid_valid", {31'd0, ifid_valid_o}, {31'd0, m_valid});
        check("halted", {31'd0, halted_o}, {31'd0, m_halt});
`ifdef FETCH_STATS_EN
        check("fetch_cnt", fetch_cnt_o, m_fetch[31:0]);
        check("stall_cnt", stall_cnt_o, m_stall[31:0]);
`endif
    endtask

    // Called ~1ns after an edge: drive, take the next edge, then compare.
    task automatic cyc(input logic r, input logic [31:0] rpc, input logic s, input logic f);
        redirect_i = r; redirect_pc_i = rpc; stall_i = s; flush_i = f;
        @(posedge clk);
        #1;
        model_step(r, rpc, s, f);
        compare_all();
    endtask

    task automatic run_to(input logic [31:0] target);
        for (int i = 0; i < 200 && m_pc != target; i++) cyc(0, 0, 0, 0);
        check("run_to_reached", m_pc, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = $urandom | 32'h1;
        rst_n = 1'b0; stall_i = 0; flush_i = 0; redirect_i = 0; redirect_pc_i = 0;
        model_reset();
        #12;
        check("rst_pc", pc_out, RPC);
        check("rst_ins", ifid_ins_o, 32'h0);
        check("rst_pc1", ifid_pc1_o, 32'h0);
        check("rst_valid", {31'd0, ifid_valid_o}, 32'd0);
        check("rst_halted", {31'd0, halted_o}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // boot edge, then first two fetches
        cyc(0, 0, 0, 0);
        check("boot_valid", {31'd0, ifid_valid_o}, 32'd0);
        cyc(0, 0, 0, 0);
        check("first_ins", ifid_ins_o, mem[0]);
        check("first_pc1", ifid_pc1_o, 32'd1);
        cyc(0, 0, 0, 0);
        check("second_ins", ifid_ins_o, mem[1]);

        // stall at pc 5
        run_to(5);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        check("stall_pc", pc_out, 32'd5);
        cyc(0, 0, 0, 0);
        check("post_stall_ins", ifid_ins_o, mem[5]);
        check("post_stall_pc1", ifid_pc1_o, 32'd6);

        // redirect beats stall
        cyc(1, 4, 1, 0);
        check("redir_pc", pc_out, 32'd4);
        check("redir_valid", {31'd0, ifid_valid_o}, 32'd0);
        cyc(0, 0, 0, 0);
        check("redir_ins", ifid_ins_o, mem[4]);
        check("redir_valid2", {31'd0, ifid_valid_o}, 32'd1);

        // flush at pc 7
        run_to(7);
        cyc(0, 0, 0, 1);
        check("flush_ins", ifid_ins_o, 32'h0);
        check("flush_pc", pc_out, 32'd8);
        cyc(0, 0, 0, 0);
        check("post_flush_ins", ifid_ins_o, mem[8]);

        // run off the end of memory
        cyc(1, 95, 0, 0);
        run_to(100);
        check("last_ins", ifid_ins_o, mem[99]);
        check("last_pc1", ifid_pc1_o, 32'd100);
        check("halt_set", {31'd0, halted_o}, 32'd1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        check("halt_pc", pc_out, 32'd100);
        check("halt_valid", {31'd0, ifid_valid_o}, 32'd0);
        cyc(1, 0, 0, 0);
        check("unhalt", {31'd0, halted_o}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            logic r, s, f;
            logic [31:0] t;
            r = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 4) == 0);
            f = !s && ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(95, 105))
                                            : 32'($urandom_range(0, 99));
            cyc(r, t, s, f);
        end

        // asynchronous reset between edges
        cyc(1, 20, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        #3; rst_n = 1'b0; #1;
        model_reset();
        check("async_pc", pc_out, RPC);
        check("async_valid", {31'd0, ifid_valid_o}, 32'd0);
        check("async_halted", {31'd0, halted_o}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        cyc(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        check("ten_fetch_pc", pc_out, 32'd10);
`ifdef FETCH_STATS_EN
        check("stats_fetch10", fetch_cnt_o, 32'd10);
        check("stats_stall3", stall_cnt_o, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
IF stage of the 5-stage MIPS pipeline; the initiator side of the combinational instruction-memory read port. Owns the program counter and drives the word address to instruction memory. Captures the returned word into the IF/ID pipeline register. Handles stall, flush, branch/jump redirect, and out-of-range halt.

Parameters:
IMEM_DEPTH, 100, number of 32-bit words in instruction memory; valid PC range 0..IMEM_DEPTH-1
RESET_PC, 0, PC value loaded on reset (word index)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
pc_out  output  32  word address to instruction memory (word-indexed, not byte)
ins_in  input  32  instruction word from memory; combinational function of pc_out
stall_i  input  1  hazard unit: hold PC and IF/ID contents
flush_i  input  1  squash the IF/ID entry (turn it into a bubble)
redirect_i  input  1  taken branch or jump resolved downstream
redirect_pc_i  input  32  target word address for redirect
ifid_ins_o  output  32  IF/ID instruction
ifid_pc1_o  output  32  IF/ID PC+1 of captured instruction
ifid_valid_o  output  1  IF/ID entry holds a real instruction
halted_o  output  1  PC is outside 0..IMEM_DEPTH-1; fetch suspended

Behaviour:
- Reset (rst_n=0, async): pc_out=RESET_PC, ifid_ins_o=0, ifid_pc1_o=0, ifid_valid_o=0, halted_o=0, FSM=S_BOOT.
- Addressing: word-indexed. Sequential next PC = pc_out+1, 32-bit, wraps modulo 2^32 with no special case.
- FSM states:
  - S_BOOT: first edge after reset release. IF/ID stays invalid (bubble). pc_out is unchanged and the memory read is in flight. Go to S_RUN.
  - S_RUN: normal fetch.
  - S_HALT: pc_out >= IMEM_DEPTH. IF/ID loads a bubble every cycle, halted_o=1. Only redirect_i leaves this state.
- Per-edge priority in S_RUN and S_HALT: redirect_i > stall_i > advance.
  - redirect_i=1: pc_out<=redirect_pc_i. IF/ID <= bubble (ins 0, valid 0), regardless of stall_i. Next state is S_HALT if redirect_pc_i >= IMEM_DEPTH, else S_RUN.
  - else stall_i=1: pc_out and all IF/ID outputs hold. flush_i is ignored while stalled (the hazard unit never asserts both).
  - else flush_i=1: IF/ID <= bubble; pc_out<=pc_out+1.
  - else advance: ifid_ins_o<=ins_in, ifid_pc1_o<=pc_out+1, ifid_valid_o<=1, pc_out<=pc_out+1.
  - If the advanced PC equals IMEM_DEPTH, next state is S_HALT. The last valid word is still captured on that edge.
- Bubble definition: ifid_ins_o=32'h0 (sll $0,$0,0 = nop), ifid_pc1_o holds its previous value, ifid_valid_o=0.
- halted_o is registered: equals (state==S_HALT).
- Latency: an instruction at PC n appears on ifid_ins_o one edge after pc_out==n with no stall. Redirect-to-first-valid-instruction takes 2 edges.
- Reset mid-operation: immediately returns all outputs to reset values. In-flight IF/ID content is discarded.
- No combinational path from any input to pc_out. pc_out is a register.

Optional Feature:
FETCH_STATS_EN:
- Defined: adds outputs fetch_cnt_o[31:0] and stall_cnt_o[31:0], both reset to 0.
  - fetch_cnt_o increments on every edge that loads ifid_valid_o=1.
  - stall_cnt_o increments on every edge with stall_i=1 and redirect_i=0.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: these ports and their registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - the fetch FSM state enum (S_BOOT, S_RUN, S_HALT);
  - the NOP_INSTR constant (32'h0);
  - the IF/ID record typedef (ins, pc1, valid), reused by the decode stage.
- One natural sub-module: ifid_reg, the IF/ID pipeline register with hold/bubble/load controls. The stats counters stay inline.

Test Plan:
- Reset release with memory words 0..3 preloaded, no stall → ifid_valid_o=0 after edge 1; ifid_ins_o=mem[0], ifid_pc1_o=1 after edge 2; mem[1] after edge 3.
- stall_i high for 3 cycles while pc_out=5 → pc_out stays 5; ifid_ins_o/ifid_pc1_o stay constant for 3 edges; after release, mem[5] is captured with pc1=6.
- redirect_i=1, redirect_pc_i=4, with stall_i=1 in the same cycle → pc_out=4, ifid_valid_o=0 next edge; mem[4] valid on the following edge.
- Run sequentially to pc_out=99 with IMEM_DEPTH=100 → mem[99] captured and halted_o=1 one edge later; subsequent edges give ifid_valid_o=0 and pc_out frozen at 100. redirect_i=1 to 0 → S_RUN, halted_o=0.
- flush_i=1 for one cycle at pc_out=7 → ifid_valid_o=0, ifid_ins_o=0, pc_out=8; next edge captures mem[8].
- Assert rst_n=0 mid-run between clock edges → pc_out=0, ifid_valid_o=0, halted_o=0 immediately. With FETCH_STATS_EN, 10 fetches and 3 stalls → fetch_cnt_o=10, stall_cnt_o=3.
